// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register saturating pending-write counters that stall issue on RAW and counter-full hazards
module register_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5,
  parameter int CNT_W    = 2,
  parameter int PEND_W   = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [IDX_W-1:0]    issue_rs,
  input  logic [IDX_W-1:0]    issue_rt,
  input  logic [IDX_W-1:0]    issue_rd,
  input  logic                issue_rd_we,
  input  logic                wb_valid,
  input  logic [IDX_W-1:0]    wb_rd,
  input  logic                flush,
  output logic                rs_busy,
  output logic                rt_busy,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [PEND_W-1:0]   total_pending,
  output logic                err_underflow
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic dest_full, inc, wb, same, up, dec, underflow;
  always_comb begin
    rs_busy     = (issue_rs != '0) && (cnt[issue_rs] != '0);
    rt_busy     = (issue_rt != '0) && (cnt[issue_rt] != '0);
    dest_full   = issue_rd_we && (issue_rd != '0) && (cnt[issue_rd] == CNT_MAX);
    issue_ready = !rs_busy && !rt_busy && !dest_full && !flush;
    inc         = issue_valid && issue_ready && issue_rd_we && (issue_rd != '0);
    wb          = wb_valid && (wb_rd != '0);
    // an issue and a writeback to the same register cancel, even when the counter is zero
    same        = inc && wb && (issue_rd == wb_rd);
    up          = inc && !same;
    dec         = wb && !same && (cnt[wb_rd] != '0);
    underflow   = wb && !same && (cnt[wb_rd] == '0);
  end
  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) busy_vec[i] = cnt[i] != '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      total_pending <= '0;
      err_underflow <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      total_pending <= '0;
      err_underflow <= 1'b0;
    end else begin
      err_underflow <= underflow;
      if (up) cnt[issue_rd] <= cnt[issue_rd] + 1'b1;
      if (dec) cnt[wb_rd] <= cnt[wb_rd] - 1'b1;
      total_pending <= total_pending + PEND_W'(up) - PEND_W'(dec);
    end
  end
endmodule

// File: tb/tb_register_scoreboard.sv
// tb_register_scoreboard: directed stimulus pushes expected outputs into a queue; a negedge monitor pops and compares
module tb_register_scoreboard;
  logic clk = 1'b0;
  logic reset;
  logic issue_valid, issue_ready, issue_rd_we, wb_valid, flush;
  logic [4:0] issue_rs, issue_rt, issue_rd, wb_rd;
  logic rs_busy, rt_busy, err_underflow;
  logic [31:0] busy_vec;
  logic [6:0] total_pending;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string name;
    logic rdy, rsb, rtb;
    logic [31:0] busy;
    logic [6:0] pend;
    logic err;
  } exp_t;
  exp_t q[$];

  register_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .busy_vec(busy_vec),
    .total_pending(total_pending), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if ({issue_ready, rs_busy, rt_busy, busy_vec, total_pending, err_underflow} !==
          {e.rdy, e.rsb, e.rtb, e.busy, e.pend, e.err}) begin
        n_bad++;
        $display("FAIL %s: got rdy=%b rs=%b rt=%b busy=%h pend=%0d err=%b, want rdy=%b rs=%b rt=%b busy=%h pend=%0d err=%b",
                 e.name, issue_ready, rs_busy, rt_busy, busy_vec, total_pending, err_underflow,
                 e.rdy, e.rsb, e.rtb, e.busy, e.pend, e.err);
      end
    end
  end

  task automatic drv(input logic iv, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic we, input logic wv, input logic [4:0] wrd, input logic fl);
    issue_valid = iv; issue_rs = rs; issue_rt = rt; issue_rd = rd; issue_rd_we = we;
    wb_valid = wv; wb_rd = wrd; flush = fl;
  endtask

  task automatic expect_out(input string name, input logic rdy, input logic rsb, input logic rtb,
                            input logic [31:0] busy, input logic [6:0] pend, input logic err);
    exp_t e;
    e.name = name; e.rdy = rdy; e.rsb = rsb; e.rtb = rtb; e.busy = busy; e.pend = pend; e.err = err;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] busy, input logic [6:0] pend, input logic err);
    n_cmp++;
    if ({busy_vec, total_pending, err_underflow} !== {busy, pend, err}) begin
      n_bad++;
      $display("FAIL %s: got busy=%h pend=%0d err=%b, want busy=%h pend=%0d err=%b",
               name, busy_vec, total_pending, err_underflow, busy, pend, err);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #7 expect_out("rst_hold", 1, 0, 0, 32'h0, 0, 0);
    chk("rst_direct", 32'h0, 0, 0);
    #5 reset = 1'b1;
    step();
    expect_out("reset_idle", 1, 0, 0, 32'h0, 0, 0);
    drv(1, 0, 0, 5, 1, 0, 0, 0); expect_out("raw_issue", 1, 0, 0, 32'h0, 0, 0); step();
    drv(0, 5, 5, 0, 0, 0, 0, 0); expect_out("raw_busy", 0, 1, 1, 32'h20, 1, 0); step();
    expect_out("raw_hold", 0, 1, 1, 32'h20, 1, 0); step();
    drv(0, 5, 5, 0, 0, 1, 5, 0); expect_out("raw_wb_nobypass", 0, 1, 1, 32'h20, 1, 0); step();
    drv(0, 5, 5, 0, 0, 0, 0, 0); expect_out("raw_release", 1, 0, 0, 32'h0, 0, 0); step();
    drv(1, 0, 0, 7, 1, 0, 0, 0); step();
    expect_out("waw_one", 1, 0, 0, 32'h80, 1, 0); step(); step();
    expect_out("waw_full", 0, 0, 0, 32'h80, 3, 0); step();
    expect_out("waw_stall", 0, 0, 0, 32'h80, 3, 0);
    drv(1, 0, 0, 7, 1, 1, 7, 0); step();
    drv(0, 0, 0, 7, 1, 0, 0, 0); expect_out("waw_free", 1, 0, 0, 32'h80, 2, 0); step();
    drv(0, 0, 0, 0, 0, 1, 7, 0); step(); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0); expect_out("waw_drain", 1, 0, 0, 32'h0, 0, 0); step();
    drv(1, 0, 0, 9, 1, 0, 0, 0); step();
    drv(1, 0, 0, 9, 1, 1, 9, 0); expect_out("sim_pre", 1, 0, 0, 32'h200, 1, 0); step();
    drv(1, 0, 0, 10, 1, 1, 10, 0); expect_out("sim_same_reg", 1, 0, 0, 32'h200, 1, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0); expect_out("sim_zero_cnt", 1, 0, 0, 32'h200, 1, 0); step();
    drv(0, 0, 0, 0, 0, 1, 9, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0); expect_out("sim_drain", 1, 0, 0, 32'h0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 1, 12, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0); expect_out("uf_pulse", 1, 0, 0, 32'h0, 0, 1); step();
    expect_out("uf_gone", 1, 0, 0, 32'h0, 0, 0);
    chk("uf_expired", 32'h0, 0, 0);
    step();
    drv(1, 0, 0, 0, 1, 1, 0, 0); expect_out("reg0_ready", 1, 0, 0, 32'h0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0); expect_out("reg0_none", 1, 0, 0, 32'h0, 0, 0); step();
    drv(1, 0, 0, 3, 1, 0, 0, 0); step(); step();
    drv(1, 0, 0, 4, 1, 0, 0, 0); step();
    drv(1, 0, 0, 5, 1, 1, 3, 1); expect_out("flush_gate", 0, 0, 0, 32'h18, 3, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0); expect_out("flush_clear", 1, 0, 0, 32'h0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 1, 12, 1); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0); expect_out("flush_err", 1, 0, 0, 32'h0, 0, 0); step();
    drv(1, 0, 0, 3, 1, 0, 0, 0); step(); step();
    drv(1, 0, 0, 4, 1, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0); expect_out("arst_pre", 1, 0, 0, 32'h18, 3, 0); step();
    #2 reset = 1'b0;
    #1 chk("arst_direct", 32'h0, 0, 0);
    expect_out("arst_clear", 1, 0, 0, 32'h0, 0, 0);
    step();
    reset = 1'b1;
    drv(1, 0, 0, 6, 1, 0, 0, 0); step();
    drv(0, 6, 0, 0, 0, 0, 0, 0); expect_out("post_rst", 0, 1, 0, 32'h40, 1, 0); step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
